fcp_slave_cmd: RTL
==================

Name: fcp_slave_cmd

Overview:
- Command layer between the FCP PHY controllers: consumes decoded frames from fcp_rx_ctrl and drives the request side of fcp_tx_ctrl (tx_en/tx_type/tx_data).
- Implements single-byte register write/read over FCP, a ping response, and master-reset handling against a small local register file.
- Exposes the register file to local logic.

Parameters:
NREG, 16, number of 8-bit registers; address width AW = clog2(NREG).
DEV_ID, 8'hA5, read-only value of register 0.
RESP_DLY, 8, clk cycles between accepted request and tx_en assertion (bus turnaround).
TX_TIMEOUT, 4096, max clk cycles tx_en stays high without tx_done.

Ports:
clk  in  1  single clock (same clock as fcp_rx_ctrl)
rst  in  1  asynchronous, active-high reset
rx_data  in  24  frame from fcp_rx_ctrl: [23:16] cmd, [15:8] addr, [7:0] wdata
rx_data_valid  in  1  one-cycle strobe, rx_data valid
ping_from_master  in  1  one-cycle strobe
reset_from_master  in  1  one-cycle strobe
rx_own_bus  out  1  to fcp_rx_ctrl; 1 when not responding
tx_en  out  1  level request to fcp_tx_ctrl
tx_type  out  1  1 = ping/ack frame, 0 = data frame
tx_data  out  16  response payload
tx_done  in  1  one-cycle strobe from fcp_tx_ctrl
host_addr  in  AW  local read/write address
host_rdata  out  8  combinational reg[host_addr]
host_we  in  1  local write strobe
host_wdata  in  8  local write data
reg_wr_pulse  out  1  one-cycle pulse on FCP-originated write
reg_wr_addr  out  AW  address of that write
ovr_cnt  out  8  saturating count of requests dropped while busy
timeout_err  out  1  sticky, cleared by rst or reset_from_master

Behaviour:
- Reset: state IDLE; tx_en=0, tx_type=1, tx_data=0, rx_own_bus=1, reg_wr_pulse=0, reg_wr_addr=0, ovr_cnt=0, timeout_err=0; reg[0]=DEV_ID, reg[1..NREG-1]=0.
- Commands: 8'h0B SBRWR, 8'h0C SBRRD. Address valid iff addr < NREG.
- States: IDLE, DELAY, TX.
- IDLE, rx_data_valid:
  - SBRWR, valid addr != 0: reg[addr] <= wdata next edge; reg_wr_pulse=1 for one cycle with reg_wr_addr=addr; response ack (tx_type=1, tx_data=0).
  - SBRWR to addr 0: no write, no pulse, ack still sent.
  - SBRRD, valid addr: response tx_type=0, tx_data={8'h00, reg[addr]}, captured at accept.
  - Invalid addr or unknown cmd: no response, stay IDLE.
  - Accepted request -> DELAY, counter cleared.
- IDLE, ping_from_master: response ack, -> DELAY. If ping and rx_data_valid coincide, the data frame wins and the ping is dropped (ovr_cnt+1).
- DELAY: rx_own_bus=0. After RESP_DLY cycles -> TX, tx_en=1. tx_type/tx_data stable from accept until return to IDLE.
- TX:
  - tx_en held high. On tx_done sampled high: tx_en=0 next cycle, -> IDLE, rx_own_bus=1.
  - Timeout counter reaches TX_TIMEOUT-1 without tx_done: tx_en=0, timeout_err=1, -> IDLE.
- rx_data_valid or ping in DELAY/TX: ignored, ovr_cnt increments, saturating at 255.
- reset_from_master, any state: next cycle reg file returns to reset values, tx_en=0, -> IDLE, timeout_err=0, ovr_cnt unchanged. It overrides a same-cycle rx_data_valid.
- Host write: reg[host_addr] <= host_wdata when host_we. Writes to addr 0 or addr >= NREG are ignored. Same cycle/same addr as an FCP write: the FCP write wins.
- host_rdata for addr >= NREG reads 8'h00.

Decomposition:
- Package fcp_pkg holds: command codes (SBRWR, SBRRD); state enum; rx_data field offsets; the TX_TYPE_ACK/TX_TYPE_DATA constants, shared with fcp_tx_ctrl.
- One natural sub-module, fcp_slave_regfile: the register array, host port, write arbitration and DEV_ID read-only slot. The FSM stays in the top.

Test Plan:
1. SBRWR rx_data=24'h0B_03_5A -> reg_wr_pulse with addr 3; host_addr=3 reads 8'h5A; after 8 cycles tx_en=1, tx_type=1; tx_done -> tx_en=0 next cycle.
2. SBRRD 24'h0C_00_xx -> tx_type=0, tx_data=16'h00A5; SBRWR to addr 0 leaves reg[0]=8'hA5 and produces no reg_wr_pulse.
3. SBRRD addr 8'h20 (NREG=16) and cmd 8'h55 -> no tx_en, state stays IDLE, ovr_cnt stays 0.
4. Second rx_data_valid during DELAY and 300 pings during TX -> ovr_cnt saturates at 255; only the first response is sent.
5. tx_done withheld -> tx_en falls after 4096 cycles, timeout_err=1; then reset_from_master -> timeout_err=0, reg[3]=0.
6. host_we to addr 3 in the same cycle as FCP SBRWR to addr 3 with wdata 8'h11 vs host_wdata 8'h22 -> reg[3]=8'h11; rst asserted mid-TX -> tx_en drops immediately.

Source files
------------

// File: rtl/fcp_pkg.sv
// Shared FCP definitions: command codes, slave FSM states, rx frame layout and tx frame types.
package fcp_pkg;

  localparam logic [7:0] CMD_SBRWR = 8'h0B;
  localparam logic [7:0] CMD_SBRRD = 8'h0C;

  // Field offsets inside the 24-bit frame from fcp_rx_ctrl
  localparam int unsigned RX_CMD_LSB   = 16;
  localparam int unsigned RX_ADDR_LSB  = 8;
  localparam int unsigned RX_WDATA_LSB = 0;

  localparam logic TX_TYPE_ACK  = 1'b1;
  localparam logic TX_TYPE_DATA = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DELAY = 2'd1,
    ST_TX    = 2'd2
  } state_e;

endpackage

// File: rtl/fcp_slave_regfile.sv
// Slave register file: slot 0 is the read-only device id, FCP writes beat host writes.
module fcp_slave_regfile #(
  parameter int unsigned NREG   = 16,
  parameter logic [7:0]  DEV_ID = 8'hA5,
  localparam int unsigned AW    = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          fcp_we_i,
  input  logic [AW-1:0] fcp_addr_i,
  input  logic [7:0]    fcp_wdata_i,
  input  logic [AW-1:0] fcp_raddr_i,
  output logic [7:0]    fcp_rdata_o,
  input  logic [AW-1:0] host_addr_i,
  input  logic          host_we_i,
  input  logic [7:0]    host_wdata_i,
  output logic [7:0]    host_rdata_o
);

  logic [7:0] mem_q [NREG];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NREG; i++) begin
        mem_q[i] <= (i == 0) ? DEV_ID : 8'h00;
      end
    end else begin
      // Slot 0 is never written; out-of-range addresses match no slot
      for (int unsigned i = 1; i < NREG; i++) begin
        if (clr_i) begin
          mem_q[i] <= 8'h00;
        end else if (fcp_we_i && (fcp_addr_i == AW'(i))) begin
          mem_q[i] <= fcp_wdata_i;
        end else if (host_we_i && (host_addr_i == AW'(i))) begin
          mem_q[i] <= host_wdata_i;
        end
      end
    end
  end

  always_comb begin
    fcp_rdata_o  = (32'(fcp_raddr_i) < NREG) ? mem_q[fcp_raddr_i] : 8'h00;
    host_rdata_o = (32'(host_addr_i) < NREG) ? mem_q[host_addr_i] : 8'h00;
  end

endmodule

// File: rtl/fcp_slave_cmd.sv
// FCP slave command layer: decodes rx frames, runs register read/write/ping and
// schedules the response to fcp_tx_ctrl after a bus-turnaround delay.
module fcp_slave_cmd
  import fcp_pkg::*;
#(
  parameter int unsigned NREG       = 16,
  parameter logic [7:0]  DEV_ID     = 8'hA5,
  parameter int unsigned RESP_DLY   = 8,
  parameter int unsigned TX_TIMEOUT = 4096,
  localparam int unsigned AW        = $clog2(NREG)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [23:0]   rx_data,
  input  logic          rx_data_valid,
  input  logic          ping_from_master,
  input  logic          reset_from_master,
  output logic          rx_own_bus,
  output logic          tx_en,
  output logic          tx_type,
  output logic [15:0]   tx_data,
  input  logic          tx_done,
  input  logic [AW-1:0] host_addr,
  output logic [7:0]    host_rdata,
  input  logic          host_we,
  input  logic [7:0]    host_wdata,
  output logic          reg_wr_pulse,
  output logic [AW-1:0] reg_wr_addr,
  output logic [7:0]    ovr_cnt,
  output logic          timeout_err
);

  localparam int unsigned CNT_MAX = (TX_TIMEOUT > RESP_DLY) ? TX_TIMEOUT : RESP_DLY;
  localparam int unsigned CW      = $clog2(CNT_MAX + 1);

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          tx_en_q, tx_type_q, rx_own_bus_q, reg_wr_pulse_q, timeout_err_q;
  logic [15:0]   tx_data_q;
  logic [AW-1:0] reg_wr_addr_q;
  logic [7:0]    ovr_cnt_q;

  logic [7:0] cmd_c, addr_c, wdata_c, rd_data_c;
  logic       is_wr_c, is_rd_c, addr_ok_c, accept_c, fcp_we_c, drop_c;

  // Frame decode and request classification
  always_comb begin
    cmd_c     = rx_data[RX_CMD_LSB +: 8];
    addr_c    = rx_data[RX_ADDR_LSB +: 8];
    wdata_c   = rx_data[RX_WDATA_LSB +: 8];
    is_wr_c   = (cmd_c == CMD_SBRWR);
    is_rd_c   = (cmd_c == CMD_SBRRD);
    addr_ok_c = (32'(addr_c) < NREG);
    accept_c  = (is_wr_c || is_rd_c) && addr_ok_c;
    fcp_we_c  = (state_q == ST_IDLE) && rx_data_valid && !reset_from_master &&
                is_wr_c && addr_ok_c && (addr_c != 8'h00);
    drop_c    = !reset_from_master &&
                (((state_q != ST_IDLE) && (rx_data_valid || ping_from_master)) ||
                 ((state_q == ST_IDLE) && rx_data_valid && ping_from_master));
  end

  fcp_slave_regfile #(
    .NREG   (NREG),
    .DEV_ID (DEV_ID)
  ) u_regfile (
    .clk          (clk),
    .rst          (rst),
    .clr_i        (reset_from_master),
    .fcp_we_i     (fcp_we_c),
    .fcp_addr_i   (AW'(addr_c)),
    .fcp_wdata_i  (wdata_c),
    .fcp_raddr_i  (AW'(addr_c)),
    .fcp_rdata_o  (rd_data_c),
    .host_addr_i  (host_addr),
    .host_we_i    (host_we),
    .host_wdata_i (host_wdata),
    .host_rdata_o (host_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      tx_en_q        <= 1'b0;
      tx_type_q      <= TX_TYPE_ACK;
      tx_data_q      <= 16'h0000;
      rx_own_bus_q   <= 1'b1;
      reg_wr_pulse_q <= 1'b0;
      reg_wr_addr_q  <= '0;
      ovr_cnt_q      <= 8'h00;
      timeout_err_q  <= 1'b0;
    end else begin
      reg_wr_pulse_q <= 1'b0;
      if (drop_c && (ovr_cnt_q != 8'hFF)) begin
        ovr_cnt_q <= ovr_cnt_q + 8'd1;
      end
      if (reset_from_master) begin
        state_q       <= ST_IDLE;
        cnt_q         <= '0;
        tx_en_q       <= 1'b0;
        tx_type_q     <= TX_TYPE_ACK;
        tx_data_q     <= 16'h0000;
        rx_own_bus_q  <= 1'b1;
        timeout_err_q <= 1'b0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            // A data frame takes priority over a coincident ping
            if (rx_data_valid) begin
              if (fcp_we_c) begin
                reg_wr_pulse_q <= 1'b1;
                reg_wr_addr_q  <= AW'(addr_c);
              end
              if (accept_c) begin
                state_q      <= ST_DELAY;
                cnt_q        <= '0;
                rx_own_bus_q <= 1'b0;
                tx_type_q    <= is_wr_c ? TX_TYPE_ACK : TX_TYPE_DATA;
                tx_data_q    <= is_wr_c ? 16'h0000 : {8'h00, rd_data_c};
              end
            end else if (ping_from_master) begin
              state_q      <= ST_DELAY;
              cnt_q        <= '0;
              rx_own_bus_q <= 1'b0;
              tx_type_q    <= TX_TYPE_ACK;
              tx_data_q    <= 16'h0000;
            end
          end
          ST_DELAY: begin
            if (cnt_q == CW'(RESP_DLY - 1)) begin
              state_q <= ST_TX;
              cnt_q   <= '0;
              tx_en_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          ST_TX: begin
            if (tx_done) begin
              state_q      <= ST_IDLE;
              tx_en_q      <= 1'b0;
              rx_own_bus_q <= 1'b1;
            end else if (cnt_q == CW'(TX_TIMEOUT - 1)) begin
              state_q       <= ST_IDLE;
              tx_en_q       <= 1'b0;
              rx_own_bus_q  <= 1'b1;
              timeout_err_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          default: begin
            state_q      <= ST_IDLE;
            tx_en_q      <= 1'b0;
            rx_own_bus_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign rx_own_bus   = rx_own_bus_q;
  assign tx_en        = tx_en_q;
  assign tx_type      = tx_type_q;
  assign tx_data      = tx_data_q;
  assign reg_wr_pulse = reg_wr_pulse_q;
  assign reg_wr_addr  = reg_wr_addr_q;
  assign ovr_cnt      = ovr_cnt_q;
  assign timeout_err  = timeout_err_q;

endmodule
